rgb_framer: RTL and testbench

Framing stage directly downstream of the debayer ISP. It consumes the RGB pixel stream (`rgb_out` qualified by `reading`) and a frame-start pulse from the CSI packet decoder. It emits a registered pixel stream tagged with x/y coordinates and start/end-of-line/frame markers, which the display/output path uses. It also detects truncated frames and counts pixels arriving outside a frame.

---
 rtl/rgb_framer_if.sv | 39 +++
 rtl/rgb_framer.sv | 164 ++++++++++++++++
 tb/tb_rgb_framer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rgb_framer_if.sv
// Pixel bus between the debayer/CSI side and the framer, plus framer status.
// The master modport is the upstream driver; the slave modport is the framer.
interface rgb_framer_if #(
    parameter int unsigned LINE_LENGTH = 640,
    parameter int unsigned NUM_LINES   = 480,
    parameter int unsigned RGB_WIDTH   = 24
);
    localparam int unsigned X_W = $clog2(LINE_LENGTH);
    localparam int unsigned Y_W = $clog2(NUM_LINES);

    logic                 frame_start;
    logic [RGB_WIDTH-1:0] rgb_in;
    logic                 rgb_in_valid;

    logic                 pix_valid;
    logic [RGB_WIDTH-1:0] pix_data;
    logic [X_W-1:0]       pix_x;
    logic [Y_W-1:0]       pix_y;
    logic                 pix_sol;
    logic                 pix_eol;
    logic                 pix_sof;
    logic                 pix_eof;
    logic                 frame_active;
    logic                 err_short_frame;
    logic [15:0]          drop_cnt;
    logic [15:0]          frame_cnt;

    modport master (
        output frame_start, rgb_in, rgb_in_valid,
        input  pix_valid, pix_data, pix_x, pix_y, pix_sol, pix_eol, pix_sof, pix_eof,
        input  frame_active, err_short_frame, drop_cnt, frame_cnt
    );

    modport slave (
        input  frame_start, rgb_in, rgb_in_valid,
        output pix_valid, pix_data, pix_x, pix_y, pix_sol, pix_eol, pix_sof, pix_eof,
        output frame_active, err_short_frame, drop_cnt, frame_cnt
    );
endinterface

// File: rtl/rgb_framer.sv
// Frames the debayered RGB stream: tags pixels with x/y and line/frame markers,
// flags frames restarted early and counts pixels arriving outside a frame.
module rgb_framer #(
    parameter int unsigned LINE_LENGTH = 640,
    parameter int unsigned NUM_LINES   = 480,
    parameter int unsigned RGB_WIDTH   = 24
) (
    input logic          clk,
    input logic          rst,
    rgb_framer_if.slave  bus
);
    localparam int unsigned X_W   = $clog2(LINE_LENGTH);
    localparam int unsigned Y_W   = $clog2(NUM_LINES);
    localparam int unsigned CNT_W = 16;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    localparam logic [X_W-1:0]   X_LAST  = X_W'(LINE_LENGTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(NUM_LINES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]           state_q, state_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;

    logic                 pix_valid_q, pix_valid_d;
    logic [RGB_WIDTH-1:0] pix_data_q, pix_data_d;
    logic [X_W-1:0]       pix_x_q, pix_x_d;
    logic [Y_W-1:0]       pix_y_q, pix_y_d;
    logic                 sol_q, sol_d, eol_q, eol_d;
    logic                 sof_q, sof_d, eof_q, eof_d;
    logic                 active_q, active_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;

    logic                 at_eol;
    logic                 at_last_line;
    logic                 eof_pix;
    logic [CNT_W-1:0]     drop_sat;

    assign at_eol       = (x_q == X_LAST);
    assign at_last_line = (y_q == Y_LAST);
    assign eof_pix      = bus.rgb_in_valid && at_eol && at_last_line;
    assign drop_sat     = (drop_cnt_q == CNT_MAX) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);

    // Next-state, counter and output-register values
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_valid_d = 1'b0;
        pix_data_d  = pix_data_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        sol_d       = 1'b0;
        eol_d       = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        err_d       = 1'b0;
        drop_cnt_d  = drop_cnt_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            ACTIVE: begin
                // A restart only spares the pixel if that pixel closes the frame
                if (bus.rgb_in_valid && (!bus.frame_start || eof_pix)) begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = bus.rgb_in;
                    pix_x_d     = x_q;
                    pix_y_d     = y_q;
                    sol_d       = (x_q == '0);
                    eol_d       = at_eol;
                    sof_d       = (x_q == '0) && (y_q == '0);
                    eof_d       = eof_pix;
                    if (at_eol) begin
                        x_d = '0;
                        y_d = at_last_line ? '0 : y_q + Y_W'(1);
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                    if (eof_pix) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        state_d     = IDLE;
                    end
                end
                if (bus.frame_start) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ACTIVE;
                    if (!eof_pix) begin
                        err_d = 1'b1;
                        if (bus.rgb_in_valid) begin
                            drop_cnt_d = drop_sat;
                        end
                    end
                end
            end
            default: begin
                if (bus.rgb_in_valid) begin
                    drop_cnt_d = drop_sat;
                end
                if (bus.frame_start) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ACTIVE;
                end
            end
        endcase

        active_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            sol_q       <= 1'b0;
            eol_q       <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            sol_q       <= sol_d;
            eol_q       <= eol_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            active_q    <= active_d;
            err_q       <= err_d;
            drop_cnt_q  <= drop_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.pix_valid       = pix_valid_q;
    assign bus.pix_data        = pix_data_q;
    assign bus.pix_x           = pix_x_q;
    assign bus.pix_y           = pix_y_q;
    assign bus.pix_sol         = sol_q;
    assign bus.pix_eol         = eol_q;
    assign bus.pix_sof         = sof_q;
    assign bus.pix_eof         = eof_q;
    assign bus.frame_active    = active_q;
    assign bus.err_short_frame = err_q;
    assign bus.drop_cnt        = drop_cnt_q;
    assign bus.frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_rgb_framer.sv
// Directed bench for rgb_framer with a 4x3 frame: per-cycle vector table plus
// hand sequences for counters, async reset and drop counter saturation.
module tb_rgb_framer;
    localparam int unsigned LL = 4;
    localparam int unsigned NL = 3;

    typedef struct {
        logic        fs;
        logic        v;
        logic [23:0] d;
        logic        epv;
        logic [23:0] ed;
        logic [1:0]  ex;
        logic [1:0]  ey;
        logic [3:0]  emk;   // {sol, eol, sof, eof}
        logic        eact;
        logic        eerr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vec_t vecs[$];
    int   seg_end[$];
    int   n_vec = 0;
    int   n_bad = 0;

    rgb_framer_if #(.LINE_LENGTH(LL), .NUM_LINES(NL), .RGB_WIDTH(24)) ifc ();

    rgb_framer #(.LINE_LENGTH(LL), .NUM_LINES(NL), .RGB_WIDTH(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    function automatic void add(logic fs, logic v, int d, logic epv, int x, int y,
                                logic [3:0] mk, logic act, logic err);
        vec_t t;
        t.fs = fs; t.v = v; t.d = 24'(d);
        t.epv = epv; t.ed = 24'(d); t.ex = 2'(x); t.ey = 2'(y);
        t.emk = mk; t.eact = act; t.eerr = err;
        vecs.push_back(t);
    endfunction

    // Pixels with frame index first..first+count-1 of a 4x3 frame
    function automatic void gen(int first, int count, bit gapped);
        for (int i = first; i < first + count; i++) begin
            int         x = i % 4;
            int         y = i / 4;
            logic [3:0] mk = {x == 0, x == 3, i == 0, i == 11};
            add(1'b0, 1'b1, i + 1, 1'b1, x, y, mk, i != 11, 1'b0);
            if (gapped && i != first + count - 1)
                add(1'b0, 1'b0, 0, 1'b0, 0, 0, 4'b0000, 1'b1, 1'b0);
        end
    endfunction

    task automatic run_seg(input int k);
        int lo = (k == 0) ? 0 : seg_end[k-1];
        for (int i = lo; i < seg_end[k]; i++) begin
            vec_t t = vecs[i];
            logic [3:0] mk;
            bit ok;
            @(negedge clk);
            ifc.frame_start  = t.fs;
            ifc.rgb_in_valid = t.v;
            ifc.rgb_in       = t.d;
            @(posedge clk);
            #1;
            mk = {ifc.pix_sol, ifc.pix_eol, ifc.pix_sof, ifc.pix_eof};
            ok = (ifc.pix_valid == t.epv) && (ifc.frame_active == t.eact) &&
                 (ifc.err_short_frame == t.eerr) && (mk == (t.epv ? t.emk : 4'b0000));
            if (t.epv)
                ok = ok && (ifc.pix_data == t.ed) && (ifc.pix_x == t.ex) && (ifc.pix_y == t.ey);
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec%0d: got v=%0b d=%06h x=%0d y=%0d mk=%04b act=%0b err=%0b, want v=%0b d=%06h x=%0d y=%0d mk=%04b act=%0b err=%0b",
                         i, ifc.pix_valid, ifc.pix_data, ifc.pix_x, ifc.pix_y, mk,
                         ifc.frame_active, ifc.err_short_frame,
                         t.epv, t.ed, t.ex, t.ey, t.emk, t.eact, t.eerr);
            end
        end
        @(negedge clk);
        ifc.frame_start  = 1'b0;
        ifc.rgb_in_valid = 1'b0;
    endtask

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic check_zero(input string name);
        logic [40:0] all;
        all = {ifc.pix_valid, ifc.pix_data, ifc.pix_x, ifc.pix_y, ifc.pix_sol, ifc.pix_eol,
               ifc.pix_sof, ifc.pix_eof, ifc.frame_active, ifc.err_short_frame, 7'b0};
        n_vec++;
        if (all !== '0 || ifc.drop_cnt !== 16'h0 || ifc.frame_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL %s: got outputs %h drop=%0h frames=%0h, want all zero",
                     name, all, ifc.drop_cnt, ifc.frame_cnt);
        end
    endtask

    initial begin
        ifc.frame_start  = 1'b0;
        ifc.rgb_in_valid = 1'b0;
        ifc.rgb_in       = '0;

        // Seg 0: basic frame, hand-computed markers
        add(1, 0, 0,  0, 0, 0, 4'b0000, 1, 0);
        add(0, 1, 1,  1, 0, 0, 4'b1010, 1, 0);
        add(0, 1, 2,  1, 1, 0, 4'b0000, 1, 0);
        add(0, 1, 3,  1, 2, 0, 4'b0000, 1, 0);
        add(0, 1, 4,  1, 3, 0, 4'b0100, 1, 0);
        add(0, 1, 5,  1, 0, 1, 4'b1000, 1, 0);
        add(0, 1, 6,  1, 1, 1, 4'b0000, 1, 0);
        add(0, 1, 7,  1, 2, 1, 4'b0000, 1, 0);
        add(0, 1, 8,  1, 3, 1, 4'b0100, 1, 0);
        add(0, 1, 9,  1, 0, 2, 4'b1000, 1, 0);
        add(0, 1, 10, 1, 1, 2, 4'b0000, 1, 0);
        add(0, 1, 11, 1, 2, 2, 4'b0000, 1, 0);
        add(0, 1, 12, 1, 3, 2, 4'b0101, 0, 0);
        seg_end.push_back(vecs.size());
        // Seg 1: gapped frame
        add(1, 0, 0, 0, 0, 0, 4'b0000, 1, 0);
        gen(0, 12, 1);
        seg_end.push_back(vecs.size());
        // Seg 2: idle pixels, then pixel coincident with frame_start
        for (int i = 0; i < 5; i++) add(0, 1, 'h100 + i, 0, 0, 0, 4'b0000, 0, 0);
        add(1, 1, 'hAA, 0, 0, 0, 4'b0000, 1, 0);
        seg_end.push_back(vecs.size());
        // Seg 3: 7 pixels, restart with a dropped pixel, then full frame
        gen(0, 7, 0);
        add(1, 1, 'h55, 0, 0, 0, 4'b0000, 1, 1);
        gen(0, 12, 0);
        seg_end.push_back(vecs.size());
        // Seg 4: back-to-back frames, restart on the eof pixel
        add(1, 0, 0, 0, 0, 0, 4'b0000, 1, 0);
        gen(0, 11, 0);
        add(1, 1, 12, 1, 3, 2, 4'b0101, 1, 0);
        gen(0, 12, 0);
        seg_end.push_back(vecs.size());
        // Seg 5: partial frame before reset
        add(1, 0, 0, 0, 0, 0, 4'b0000, 1, 0);
        gen(0, 5, 0);
        seg_end.push_back(vecs.size());
        // Seg 6: after reset, drops until frame_start, then a full frame
        add(0, 1, 'h77, 0, 0, 0, 4'b0000, 0, 0);
        add(0, 1, 'h78, 0, 0, 0, 4'b0000, 0, 0);
        add(1, 0, 0,    0, 0, 0, 4'b0000, 1, 0);
        gen(0, 12, 0);
        seg_end.push_back(vecs.size());

        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        run_seg(0);
        check16("basic_frame_cnt", ifc.frame_cnt, 16'd1);
        check16("basic_drop_cnt", ifc.drop_cnt, 16'd0);
        run_seg(1);
        check16("gapped_frame_cnt", ifc.frame_cnt, 16'd2);
        check16("gapped_drop_cnt", ifc.drop_cnt, 16'd0);
        run_seg(2);
        check16("idle_drop_cnt", ifc.drop_cnt, 16'd6);
        run_seg(3);
        check16("short_frame_cnt", ifc.frame_cnt, 16'd3);
        check16("short_drop_cnt", ifc.drop_cnt, 16'd7);
        run_seg(4);
        check16("b2b_frame_cnt", ifc.frame_cnt, 16'd5);
        check16("b2b_drop_cnt", ifc.drop_cnt, 16'd7);

        run_seg(5);
        ifc.rgb_in_valid = 1'b1;
        ifc.rgb_in       = 24'h000006;
        ifc.frame_start  = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("reset_mid_frame");
        @(negedge clk);
        ifc.rgb_in_valid = 1'b0;
        rst = 1'b0;
        run_seg(6);
        check16("post_reset_frame_cnt", ifc.frame_cnt, 16'd1);
        check16("post_reset_drop_cnt", ifc.drop_cnt, 16'd2);

        // Drop counter saturation
        @(negedge clk);
        force dut.drop_cnt_q = 16'hFFFD;
        #1;
        release dut.drop_cnt_q;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] want;
            @(negedge clk);
            ifc.rgb_in_valid = 1'b1;
            ifc.rgb_in       = 24'(i);
            @(posedge clk);
            #1;
            want = (i == 0) ? 16'hFFFE : 16'hFFFF;
            check16("drop_saturate", ifc.drop_cnt, want);
        end
        @(negedge clk);
        ifc.rgb_in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
